sfif_adc_capture: RTL and testbench

//  Write-side stage of the pop sample buffer: accepts ADC samples, writes them into the

---
 rtl/sfif_pop_pkg.sv | 17 +
 rtl/sfif_ring_ptr.sv | 31 +++
 rtl/sfif_adc_capture.sv | 141 ++++++++++++++
 tb/tb_sfif_adc_capture.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/sfif_pop_pkg.sv
// Shared definitions for the pop sample buffer: sample/pointer sizing, the capture
// state encoding and the reader-side base address.
package sfif_pop_pkg;

  localparam int SAMPLE_WIDTH = 16;
  localparam int PTR_BITS     = 10;

  localparam logic [31:0] POP_START_ADDRESS = 32'h0000_1000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    POST = 2'd2,
    DONE = 2'd3
  } cap_state_e;

endpackage

// File: rtl/sfif_ring_ptr.sv
// Wrapping ring pointer: advances on inc_i, rolls over at the top of the ring and
// flags the increment that rolls over.
module sfif_ring_ptr #(
  parameter int PTR_BITS = 10
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_n,
  input  logic                inc_i,
  output logic [PTR_BITS-1:0] ptr_o,
  output logic                wrap_o
);

  localparam logic [PTR_BITS-1:0] PTR_ONE = {{(PTR_BITS-1){1'b0}}, 1'b1};

  logic [PTR_BITS-1:0] ptr_q;
  logic [PTR_BITS-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (inc_i) ptr_d = ptr_q + PTR_ONE;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) ptr_q <= '0;
    else           ptr_q <= ptr_d;
  end

  assign ptr_o  = ptr_q;
  assign wrap_o = inc_i && (ptr_q == '1);

endmodule

// File: rtl/sfif_adc_capture.sv
// ADC capture write side: streams samples into the adc_ram ring and freezes the ring
// a programmed number of samples after the trigger.
//   state | meaning
//   IDLE  | after reset, nothing written
//   PRE   | armed, ring filling, waiting for the trigger sample
//   POST  | trigger seen, counting post-trigger samples
//   DONE  | ring frozen for the reader; further samples flag overrun
module sfif_adc_capture #(
  parameter int SAMPLE_WIDTH = sfif_pop_pkg::SAMPLE_WIDTH,
  parameter int PTR_BITS     = sfif_pop_pkg::PTR_BITS
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_n,
  input  logic [SAMPLE_WIDTH-1:0] adc_data,
  input  logic                    adc_valid,
  input  logic                    arm,
  input  logic                    trig,
  input  logic [PTR_BITS-1:0]     post_len,
  output logic                    ram_we,
  output logic [PTR_BITS-1:0]     ram_wr_addr,
  output logic [SAMPLE_WIDTH-1:0] ram_wr_data,
  output logic [PTR_BITS-1:0]     write_head,
  output logic [PTR_BITS-1:0]     trig_addr,
  output logic                    busy,
  output logic                    done,
  output logic                    wrapped,
  output logic                    overrun
);

  import sfif_pop_pkg::*;

  localparam logic [PTR_BITS:0] DEPTH   = {1'b1, {PTR_BITS{1'b0}}};
  localparam logic [PTR_BITS:0] CNT_ONE = {{PTR_BITS{1'b0}}, 1'b1};

  cap_state_e              state_q, state_d;
  logic                    trig_pend_q, trig_pend_d;
  logic [PTR_BITS:0]       post_len_q, post_len_d;
  logic [PTR_BITS:0]       post_cnt_q, post_cnt_d;
  logic [PTR_BITS-1:0]     trig_addr_q, trig_addr_d;
  logic                    wrapped_q, wrapped_d;
  logic                    overrun_q, overrun_d;
  logic                    ram_we_q;
  logic [PTR_BITS-1:0]     ram_wr_addr_q;
  logic [SAMPLE_WIDTH-1:0] ram_wr_data_q;
  logic                    wr_en;
  logic                    head_wrap;

  // Samples are written in PRE/POST regardless of arm; arm only resets control.
  assign wr_en = adc_valid && ((state_q == PRE) || (state_q == POST));

  sfif_ring_ptr #(.PTR_BITS(PTR_BITS)) u_head (
    .wb_clk_i (wb_clk_i),
    .wb_rst_n (wb_rst_n),
    .inc_i    (wr_en),
    .ptr_o    (write_head),
    .wrap_o   (head_wrap)
  );

  always_comb begin
    state_d     = state_q;
    trig_pend_d = trig_pend_q;
    post_len_d  = post_len_q;
    post_cnt_d  = post_cnt_q;
    trig_addr_d = trig_addr_q;
    wrapped_d   = wrapped_q;
    overrun_d   = overrun_q;
    if (arm) begin
      state_d     = PRE;
      trig_pend_d = 1'b0;
      wrapped_d   = 1'b0;
      overrun_d   = 1'b0;
      post_len_d  = (post_len == '0) ? DEPTH : {1'b0, post_len};
    end else begin
      case (state_q)
        PRE: begin
          if (adc_valid && (trig || trig_pend_q)) begin
            trig_pend_d = 1'b0;
            trig_addr_d = write_head;
            if (post_len_q == CNT_ONE) begin
              state_d = DONE;
            end else begin
              state_d    = POST;
              post_cnt_d = post_len_q - CNT_ONE;
            end
          end else if (trig) begin
            trig_pend_d = 1'b1;
          end
        end
        POST: begin
          if (adc_valid) begin
            post_cnt_d = post_cnt_q - CNT_ONE;
            if (post_cnt_q == CNT_ONE) state_d = DONE;
          end
        end
        DONE: begin
          if (adc_valid) overrun_d = 1'b1;
        end
        default: ;
      endcase
      if (head_wrap) wrapped_d = 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q       <= IDLE;
      trig_pend_q   <= 1'b0;
      post_len_q    <= '0;
      post_cnt_q    <= '0;
      trig_addr_q   <= '0;
      wrapped_q     <= 1'b0;
      overrun_q     <= 1'b0;
      ram_we_q      <= 1'b0;
      ram_wr_addr_q <= '0;
      ram_wr_data_q <= '0;
    end else begin
      state_q     <= state_d;
      trig_pend_q <= trig_pend_d;
      post_len_q  <= post_len_d;
      post_cnt_q  <= post_cnt_d;
      trig_addr_q <= trig_addr_d;
      wrapped_q   <= wrapped_d;
      overrun_q   <= overrun_d;
      ram_we_q    <= wr_en;
      if (wr_en) begin
        ram_wr_addr_q <= write_head;
        ram_wr_data_q <= adc_data;
      end
    end
  end

  assign ram_we      = ram_we_q;
  assign ram_wr_addr = ram_wr_addr_q;
  assign ram_wr_data = ram_wr_data_q;
  assign trig_addr   = trig_addr_q;
  assign busy        = (state_q == PRE) || (state_q == POST);
  assign done        = (state_q == DONE);
  assign wrapped     = wrapped_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_sfif_adc_capture.sv
// Directed bench for sfif_adc_capture: an adc_ram model captures the write port and
// results are compared against hand-computed values.
module tb_sfif_adc_capture;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_n;
  logic [15:0] adc_data;
  logic        adc_valid;
  logic        arm;
  logic        trig;
  logic [9:0]  post_len;
  logic        ram_we;
  logic [9:0]  ram_wr_addr;
  logic [15:0] ram_wr_data;
  logic [9:0]  write_head;
  logic [9:0]  trig_addr;
  logic        busy;
  logic        done;
  logic        wrapped;
  logic        overrun;

  int n_chk = 0;
  int n_err = 0;
  int wr_count = 0;
  int snap;
  logic [15:0] mem [0:1023];

  always #5 wb_clk_i = ~wb_clk_i;

  sfif_adc_capture dut (
    .wb_clk_i    (wb_clk_i),
    .wb_rst_n    (wb_rst_n),
    .adc_data    (adc_data),
    .adc_valid   (adc_valid),
    .arm         (arm),
    .trig        (trig),
    .post_len    (post_len),
    .ram_we      (ram_we),
    .ram_wr_addr (ram_wr_addr),
    .ram_wr_data (ram_wr_data),
    .write_head  (write_head),
    .trig_addr   (trig_addr),
    .busy        (busy),
    .done        (done),
    .wrapped     (wrapped),
    .overrun     (overrun)
  );

  always @(posedge wb_clk_i) begin
    if (ram_we) begin
      mem[ram_wr_addr] <= ram_wr_data;
      wr_count <= wr_count + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge wb_clk_i);
    #1;
  endtask

  initial begin
    wb_rst_n  = 1'b0;
    adc_valid = 1'b1;
    adc_data  = 16'h5555;
    arm       = 1'b0;
    trig      = 1'b0;
    post_len  = 10'd0;
    repeat (2) step();
    chk("rst_ram_we", {31'd0, ram_we}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);

    // 1: free-running valid with no arm writes nothing
    wb_rst_n = 1'b1;
    repeat (5) step();
    chk("t1_ram_we", {31'd0, ram_we}, 32'd0);
    chk("t1_head", {22'd0, write_head}, 32'd0);
    chk("t1_wr_count", wr_count, 32'd0);
    chk("t1_flags", {28'd0, busy, done, wrapped, overrun}, 32'd0);
    chk("t1_trig_addr", {22'd0, trig_addr}, 32'd0);

    // 2: arm and stream ten samples
    adc_valid = 1'b0;
    arm = 1'b1;
    post_len = 10'd4;
    step();
    arm = 1'b0;
    chk("t2_busy_after_arm", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      adc_valid = 1'b1;
      adc_data = 16'h0100 + 16'(i);
      step();
    end
    chk("t2_head", {22'd0, write_head}, 32'd10);
    adc_valid = 1'b0;
    step();
    for (int i = 0; i < 10; i++) chk($sformatf("t2_mem%0d", i), {16'd0, mem[i]}, 32'h0100 + 32'(i));
    chk("t2_wr_count", wr_count, 32'd10);
    chk("t2_busy", {31'd0, busy}, 32'd1);
    chk("t2_done", {31'd0, done}, 32'd0);

    // 3: pending trigger, post_len 4
    trig = 1'b1;
    step();
    trig = 1'b0;
    adc_valid = 1'b1;
    adc_data = 16'hAAAA; step();
    adc_data = 16'hBBBB; step();
    adc_data = 16'hCCCC; step();
    chk("t3_done_early", {31'd0, done}, 32'd0);
    adc_data = 16'hDDDD; step();
    chk("t3_done", {31'd0, done}, 32'd1);
    chk("t3_last_we", {31'd0, ram_we}, 32'd1);
    chk("t3_last_addr", {22'd0, ram_wr_addr}, 32'd13);
    adc_data = 16'hEEEE; step();
    adc_valid = 1'b0;
    step();
    chk("t3_trig_addr", {22'd0, trig_addr}, 32'd10);
    chk("t3_mem_trig", {16'd0, mem[10]}, 32'hAAAA);
    chk("t3_mem_last", {16'd0, mem[13]}, 32'hDDDD);
    chk("t3_wr_count", wr_count, 32'd14);
    chk("t3_head", {22'd0, write_head}, 32'd14);
    chk("t3_overrun", {31'd0, overrun}, 32'd1);
    chk("t3_busy", {31'd0, busy}, 32'd0);

    // 4: full-depth post count, trigger at head 5
    snap = wr_count;
    post_len = 10'd0;
    arm = 1'b1;
    step();
    arm = 1'b0;
    chk("t4_overrun_clr", {31'd0, overrun}, 32'd0);
    chk("t4_done_clr", {31'd0, done}, 32'd0);
    adc_valid = 1'b1;
    for (int i = 0; i < 1015; i++) begin
      adc_data = 16'(i);
      step();
    end
    chk("t4_head_pre", {22'd0, write_head}, 32'd5);
    chk("t4_wrapped_pre", {31'd0, wrapped}, 32'd1);
    trig = 1'b1;
    adc_data = 16'd1015;
    step();
    trig = 1'b0;
    chk("t4_trig_addr", {22'd0, trig_addr}, 32'd5);
    for (int i = 1016; i <= 2038; i++) begin
      chk("t4_not_done_yet", {31'd0, done}, 32'd0);
      adc_data = 16'(i);
      step();
    end
    chk("t4_done", {31'd0, done}, 32'd1);
    adc_data = 16'hFFFF;
    repeat (2) step();
    adc_valid = 1'b0;
    step();
    chk("t4_writes", wr_count - snap, 32'd2039);
    chk("t4_head", {22'd0, write_head}, 32'd5);
    chk("t4_mem_trig", {16'd0, mem[5]}, 32'd1015);
    chk("t4_mem_last", {16'd0, mem[4]}, 32'd2038);
    chk("t4_overrun", {31'd0, overrun}, 32'd1);
    chk("t4_wrapped", {31'd0, wrapped}, 32'd1);

    // 5: arm and trig together, trig must be dropped
    post_len = 10'd2;
    arm = 1'b1;
    trig = 1'b1;
    step();
    arm = 1'b0;
    trig = 1'b0;
    chk("t5_flags", {28'd0, busy, done, wrapped, overrun}, 32'h8);
    adc_valid = 1'b1;
    adc_data = 16'h0505; step();
    adc_data = 16'h0606; step();
    adc_valid = 1'b0;
    step();
    chk("t5_done", {31'd0, done}, 32'd0);
    chk("t5_busy", {31'd0, busy}, 32'd1);
    chk("t5_head", {22'd0, write_head}, 32'd7);
    chk("t5_trig_addr", {22'd0, trig_addr}, 32'd5);

    // 6: asynchronous reset during POST with a write in flight
    post_len = 10'd8;
    arm = 1'b1;
    step();
    arm = 1'b0;
    trig = 1'b1;
    adc_valid = 1'b1;
    adc_data = 16'h0707;
    step();
    trig = 1'b0;
    chk("t6_trig_addr", {22'd0, trig_addr}, 32'd7);
    adc_data = 16'h0808;
    step();
    adc_valid = 1'b0;
    chk("t6_busy", {31'd0, busy}, 32'd1);
    chk("t6_we_inflight", {31'd0, ram_we}, 32'd1);
    snap = wr_count;
    #2;
    wb_rst_n = 1'b0;
    #1;
    chk("t6_rst_we", {31'd0, ram_we}, 32'd0);
    chk("t6_rst_flags", {28'd0, busy, done, wrapped, overrun}, 32'd0);
    chk("t6_rst_head", {22'd0, write_head}, 32'd0);
    chk("t6_rst_trig_addr", {22'd0, trig_addr}, 32'd0);
    chk("t6_rst_addr", {22'd0, ram_wr_addr}, 32'd0);
    step();
    chk("t6_dropped", wr_count, snap);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
